// File: rtl/spi_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_regfile_pkg
// Brief    : Shared types and helpers for the SPI register-file peripheral.
// Revision : 1.0 - initial release
// ============================================================================
package spi_regfile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } spi_state_e;

    localparam logic c_rw_write = 1'b1;
    localparam logic c_rw_read  = 1'b0;

    function automatic int frame_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    function automatic int cnt_width(input int frame_w);
        return $clog2(frame_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_edge
// Brief    : Multi-stage synchroniser for one async input with registered
//            rise/fall pulses.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              w_sync;

    assign w_sync = r_sync[STAGES-1];

    // Chain resets low, so a fall can only follow a high level seen after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= w_sync;
            o_rise <= w_sync & ~r_prev;
            o_fall <= ~w_sync & r_prev;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_regfile_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : spi_regfile_peripheral
// Brief    : SPI mode-0 peripheral decoding write/read frames into a register
//            file. Readback on CIPO is enabled by defining SPI_READBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_regfile_peripheral
    import spi_regfile_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sclk,
    input  logic                         copi,
    input  logic                         ncs,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         frame_err
);

    localparam int c_frame_w = frame_width(ADDR_W, DATA_W);
    localparam int c_cnt_w   = cnt_width(c_frame_w);
    // Only the wider of header and data ever needs to be held at once.
    localparam int c_sh_w    = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;

    localparam logic [c_cnt_w-1:0] c_hdr_last = c_cnt_w'(ADDR_W);
    localparam logic [c_cnt_w-1:0] c_last     = c_cnt_w'(c_frame_w - 1);

    logic                    w_sclk_rise;
    logic                    w_sclk_fall;
    logic                    w_ncs_rise;
    logic                    w_ncs_fall;
    logic [SYNC_STAGES-1:0]  r_copi_sync;
    logic                    w_copi;

    spi_state_e              r_state;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_sh_w-2:0]       r_shift;
    logic [c_sh_w-1:0]       w_shift_next;
    logic                    r_rw;
    logic [ADDR_W-1:0]       r_addr;
    logic [DATA_W-1:0]       r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]     r_wr_strobe;
    logic                    r_frame_err;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (sclk),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ncs_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (ncs),
        .o_rise  (w_ncs_rise),
        .o_fall  (w_ncs_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_copi_sync <= '0;
        end else begin
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
        end
    end

    assign w_copi       = r_copi_sync[SYNC_STAGES-1];
    assign w_shift_next = {r_shift, w_copi};

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] r_out;
    logic [DATA_W-1:0] w_rd_data;
    logic              r_cipo;
    logic              r_cipo_oe;

    // Out-of-range addresses match no register and read back as zero.
    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_shift_next[ADDR_W-1:0] == ADDR_W'(k)) begin
                w_rd_data = r_regs[k];
            end
        end
    end

    assign cipo    = r_cipo;
    assign cipo_oe = r_cipo_oe;
`else
    assign cipo    = 1'b0;
    assign cipo_oe = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_wr_strobe <= '0;
            r_frame_err <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
`ifdef SPI_READBACK_EN
            r_out       <= '0;
            r_cipo      <= 1'b0;
            r_cipo_oe   <= 1'b0;
`endif
        end else begin
            r_wr_strobe <= '0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ncs_fall) begin
                        r_state <= ST_HDR;
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end
                end
                ST_HDR, ST_DATA: begin
                    // nCS rising takes priority over a coincident final SCLK edge.
                    if (w_ncs_rise) begin
                        r_state     <= ST_IDLE;
                        r_frame_err <= (r_cnt != '0);
`ifdef SPI_READBACK_EN
                        r_cipo      <= 1'b0;
                        r_cipo_oe   <= 1'b0;
`endif
                    end else begin
                        if (w_sclk_rise) begin
                            r_shift <= w_shift_next[c_sh_w-2:0];
                            r_cnt   <= r_cnt + 1'b1;
                            if (r_state == ST_HDR && r_cnt == c_hdr_last) begin
                                r_state <= ST_DATA;
                                r_rw    <= w_shift_next[ADDR_W];
                                r_addr  <= w_shift_next[ADDR_W-1:0];
`ifdef SPI_READBACK_EN
                                if (w_shift_next[ADDR_W] == c_rw_read) begin
                                    r_out     <= w_rd_data;
                                    r_cipo_oe <= 1'b1;
                                end
`endif
                            end
                            if (r_state == ST_DATA && r_cnt == c_last) begin
                                r_state <= ST_DONE;
                                if (r_rw == c_rw_write) begin
                                    for (int k = 0; k < NUM_REGS; k++) begin
                                        if (r_addr == ADDR_W'(k)) begin
                                            r_regs[k]      <= w_shift_next[DATA_W-1:0];
                                            r_wr_strobe[k] <= 1'b1;
                                        end
                                    end
                                end
                            end
                        end
`ifdef SPI_READBACK_EN
                        if (w_sclk_fall && r_state == ST_DATA && r_cipo_oe) begin
                            r_cipo <= r_out[DATA_W-1];
                            r_out  <= r_out << 1;
                        end
`endif
                    end
                end
                ST_DONE: begin
                    if (w_ncs_rise) begin
                        r_state   <= ST_IDLE;
`ifdef SPI_READBACK_EN
                        r_cipo    <= 1'b0;
                        r_cipo_oe <= 1'b0;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
            assign regs_flat[k*DATA_W +: DATA_W] = r_regs[k];
        end
    endgenerate

    assign wr_strobe = r_wr_strobe;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire
